// File: rtl/periph_bus_if.sv
// periph_bus_if: bundle of the core memory-port signals and the peripheral-side
// select/enable/status signals handled by periph_bus_ctrl.
//   master : core/peripheral side. Drives the address, requests, ready and err_clr.
//   slave  : periph_bus_ctrl. Drives the chip-select, enables, busy and error status.
interface periph_bus_if;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [3:0]  mem_wmask;
    logic [6:0]  periph_ready;
    logic        err_clr;
    logic [6:0]  cs;
    logic        rd_en;
    logic        wr_en;
    logic [3:0]  wmask_q;
    logic        mem_rbusy;
    logic        mem_wbusy;
    logic        bus_err;
    logic [1:0]  err_code;

    modport master (
        output mem_addr, mem_rstrb, mem_wmask, periph_ready, err_clr,
        input  cs, rd_en, wr_en, wmask_q, mem_rbusy, mem_wbusy, bus_err, err_code
    );

    modport slave (
        input  mem_addr, mem_rstrb, mem_wmask, periph_ready, err_clr,
        output cs, rd_en, wr_en, wmask_q, mem_rbusy, mem_wbusy, bus_err, err_code
    );
endinterface

// File: rtl/periph_bus_ctrl.sv
// periph_bus_ctrl: sequences FemtoRV32 memory-port transactions onto the SoC peripherals.
// It decodes the address into a one-hot chip-select and pulses rd_en/wr_en for one cycle.
// It holds mem_rbusy/mem_wbusy for a fixed FAST_WAIT cycles, or, for handshake slaves,
// until periph_ready. A handshake that does not arrive within TIMEOUT cycles ends the
// transaction with a timeout error.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  periph_bus_if.slave, which carries:
//        mem_addr/mem_rstrb/mem_wmask  core request
//        periph_ready                  per-slave done, indexed like cs
//        err_clr                       clears bus_err/err_code
//        cs                            one-hot select: [6]dpram [5]uart [4]gpio [3]mult
//                                      [2]div [1]bin2bcd [0]RAM
//        rd_en/wr_en/wmask_q           one-cycle enables and the latched write mask
//        mem_rbusy/mem_wbusy           wait states back to the core
//        bus_err/err_code              sticky error, 01 unmapped, 10 timeout
module periph_bus_ctrl #(
    parameter int         FAST_WAIT = 1,
    parameter int         TIMEOUT   = 255,
    parameter logic [6:0] SLOW_MASK = 7'b0001110
) (
    input  logic         clk,
    input  logic         rst,
    periph_bus_if.slave  bus
);
    localparam logic [7:0] FAST_LAST = 8'(FAST_WAIT - 1);
    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, FAST, WAIT} state_t;

    state_t     state, state_d;
    logic [6:0] cs_q, cs_d;
    logic       rd_en_q, rd_en_d;
    logic       wr_en_q, wr_en_d;
    logic [3:0] wmask_q, wmask_d;
    logic       rbusy_q, rbusy_d;
    logic       wbusy_q, wbusy_d;
    logic       err_q, err_d;
    logic [1:0] code_q, code_d;
    logic [7:0] cnt_q, cnt_d;

    logic       req_wr, req_rd;
    logic [6:0] dec;
    logic       sel_ready;
    logic       unused_addr_bits;

    // Only bit 31 and the region nibble take part in the decode.
    assign unused_addr_bits = ^{bus.mem_addr[30:20], bus.mem_addr[15:0]};

    function automatic logic [6:0] decode(input logic hi, input logic [3:0] region);
        logic [6:0] sel;
        sel = 7'b0;
        if (!hi) begin
            sel = 7'b0000001;
        end else begin
            case (region)
                4'd0:    sel = 7'b1000000;
                4'd1:    sel = 7'b0100000;
                4'd2:    sel = 7'b0010000;
                4'd3:    sel = 7'b0001000;
                4'd4:    sel = 7'b0000100;
                4'd5:    sel = 7'b0000010;
                default: sel = 7'b0000000;
            endcase
        end
        return sel;
    endfunction

    // A write wins over a simultaneous read, and the read is dropped.
    assign req_wr    = |bus.mem_wmask;
    assign req_rd    = bus.mem_rstrb & ~req_wr;
    assign dec       = decode(bus.mem_addr[31], bus.mem_addr[19:16]);
    // Only the selected slave's ready is honoured.
    assign sel_ready = |(bus.periph_ready & cs_q);

    always_comb begin
        state_d = state;
        cs_d    = cs_q;
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
        wmask_d = wmask_q;
        rbusy_d = rbusy_q;
        wbusy_d = wbusy_q;
        err_d   = err_q;
        code_d  = code_q;
        cnt_d   = cnt_q;

        // A clear is applied first so that an error raised in the same cycle overrides it.
        if (bus.err_clr) begin
            err_d  = 1'b0;
            code_d = 2'b00;
        end

        case (state)
            IDLE: begin
                if (req_wr || req_rd) begin
                    cs_d    = dec;
                    rd_en_d = req_rd;
                    wr_en_d = req_wr;
                    wmask_d = bus.mem_wmask;
                    rbusy_d = req_rd;
                    wbusy_d = req_wr;
                    cnt_d   = 8'd0;
                    state_d = (|(dec & SLOW_MASK)) ? WAIT : FAST;
                end
            end
            FAST: begin
                if (cnt_q == FAST_LAST) begin
                    rbusy_d = 1'b0;
                    wbusy_d = 1'b0;
                    state_d = IDLE;
                    if (cs_q == 7'b0) begin
                        err_d  = 1'b1;
                        code_d = 2'b01;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WAIT: begin
                // Ready in the last allowed cycle is checked first, so it wins over the timeout.
                if (sel_ready) begin
                    rbusy_d = 1'b0;
                    wbusy_d = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    rbusy_d = 1'b0;
                    wbusy_d = 1'b0;
                    state_d = IDLE;
                    err_d   = 1'b1;
                    code_d  = 2'b10;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cs_q    <= 7'b0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            wmask_q <= 4'b0;
            rbusy_q <= 1'b0;
            wbusy_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            cnt_q   <= 8'd0;
        end else begin
            state   <= state_d;
            cs_q    <= cs_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            wmask_q <= wmask_d;
            rbusy_q <= rbusy_d;
            wbusy_q <= wbusy_d;
            err_q   <= err_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.cs        = cs_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wmask_q   = wmask_q;
    assign bus.mem_rbusy = rbusy_q;
    assign bus.mem_wbusy = wbusy_q;
    assign bus.bus_err   = err_q;
    assign bus.err_code  = code_q;
endmodule

// File: tb/tb_periph_bus_ctrl.sv
// tb_periph_bus_ctrl: directed and randomized checks of periph_bus_ctrl against a
// transaction-level reference model. For each transaction the model works out the
// expected select, busy length and error outcome.
module tb_periph_bus_ctrl;
    localparam int         TO   = 8;
    localparam int         FW   = 1;
    localparam logic [6:0] SLOW = 7'b0001110;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   exp_err;
    logic [1:0] exp_code;

    always #5 clk = ~clk;

    periph_bus_if bus ();

    periph_bus_ctrl #(.FAST_WAIT(FW), .TIMEOUT(TO), .SLOW_MASK(SLOW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Address map: RAM below 0x80000000; above it, regions 0..5 are the peripherals.
    function automatic logic [6:0] ref_sel(input logic [31:0] a);
        int r;
        if (!a[31]) return 7'b0000001;
        r = int'(a[19:16]);
        if (r <= 5) return 7'(1 << (6 - r));
        return 7'b0;
    endfunction

    // Runs one transaction, starting at a negedge in which the controller is idle.
    // ready_at: cycle index (T1 = 1) in which the selected slave raises ready.
    // It returns at the negedge of the first idle cycle after the transaction.
    task automatic do_txn(input logic [31:0] addr, input bit rd, input logic [3:0] wm,
                          input int ready_at, input bit clr0, input bit clr_end,
                          input bit junk, input string tag);
        logic [6:0] sel;
        bit         is_wr, slow, set_err;
        logic [1:0] set_code;
        int         len;
        sel      = ref_sel(addr);
        is_wr    = (wm != 4'b0);
        slow     = ((sel & SLOW) != 7'b0);
        len      = slow ? ((ready_at <= TO) ? ready_at : TO) : FW;
        set_err  = slow ? (ready_at > TO) : (sel == 7'b0);
        set_code = slow ? 2'b10 : 2'b01;

        bus.mem_addr     = addr;
        bus.mem_rstrb    = rd;
        bus.mem_wmask    = wm;
        bus.err_clr      = clr0;
        bus.periph_ready = 7'($urandom) & ~sel;
        if (clr0) begin exp_err = 1'b0; exp_code = 2'b00; end

        for (int k = 1; k <= len + 1; k++) begin
            @(negedge clk);
            if (k == len + 1) begin
                if (set_err) begin exp_err = 1'b1; exp_code = set_code; end
                else if (clr_end) begin exp_err = 1'b0; exp_code = 2'b00; end
            end
            checks++; if (bus.cs !== sel) begin errors++; $display("FAIL %s cs k=%0d got %b exp %b", tag, k, bus.cs, sel); end
            checks++; if (bus.mem_rbusy !== (!is_wr && k <= len)) begin errors++; $display("FAIL %s rbusy k=%0d got %b exp %b", tag, k, bus.mem_rbusy, (!is_wr && k <= len)); end
            checks++; if (bus.mem_wbusy !== (is_wr && k <= len)) begin errors++; $display("FAIL %s wbusy k=%0d got %b exp %b", tag, k, bus.mem_wbusy, (is_wr && k <= len)); end
            checks++; if (bus.rd_en !== (k == 1 && !is_wr)) begin errors++; $display("FAIL %s rd_en k=%0d got %b exp %b", tag, k, bus.rd_en, (k == 1 && !is_wr)); end
            checks++; if (bus.wr_en !== (k == 1 && is_wr)) begin errors++; $display("FAIL %s wr_en k=%0d got %b exp %b", tag, k, bus.wr_en, (k == 1 && is_wr)); end
            if (k == 1) begin
                checks++; if (bus.wmask_q !== wm) begin errors++; $display("FAIL %s wmask_q got %b exp %b", tag, bus.wmask_q, wm); end
            end
            checks++; if (bus.bus_err !== exp_err) begin errors++; $display("FAIL %s bus_err k=%0d got %b exp %b", tag, k, bus.bus_err, exp_err); end
            checks++; if (bus.err_code !== exp_code) begin errors++; $display("FAIL %s err_code k=%0d got %b exp %b", tag, k, bus.err_code, exp_code); end

            if (k <= len) begin
                // Requests during busy must be ignored, as must ready from other slaves.
                bus.mem_rstrb    = junk ? 1'($urandom) : 1'b0;
                bus.mem_wmask    = junk ? 4'($urandom) : 4'b0;
                bus.mem_addr     = junk ? $urandom : addr;
                bus.err_clr      = clr_end && (k == len);
                bus.periph_ready = (7'($urandom) & ~sel) | ((slow && k == ready_at) ? sel : 7'b0);
            end
        end
        bus.mem_rstrb = 1'b0;
        bus.mem_wmask = 4'b0;
        bus.err_clr   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({bus.cs, bus.rd_en, bus.wr_en, bus.wmask_q, bus.mem_rbusy, bus.mem_wbusy, bus.bus_err, bus.err_code} !== 18'b0) begin
            errors++; $display("FAIL reset outputs got %b exp 0", {bus.cs, bus.rd_en, bus.wr_en, bus.wmask_q, bus.mem_rbusy, bus.mem_wbusy, bus.bus_err, bus.err_code});
        end
        rst = 1'b0;
        exp_err = 1'b0; exp_code = 2'b00;
    endtask

    task automatic test_ram_read();
        do_txn(32'h0000_0040, 1'b1, 4'b0, 1, 1'b0, 1'b0, 1'b0, "ram_rd");
    endtask

    task automatic test_uart_write();
        do_txn(32'h8001_0000, 1'b0, 4'b1111, 1, 1'b0, 1'b0, 1'b0, "uart_wr");
    endtask

    task automatic test_div_read();
        @(negedge clk);
        do_txn(32'h8004_0000, 1'b1, 4'b0, 4, 1'b0, 1'b0, 1'b0, "div_rd");
    endtask

    task automatic test_timeout();
        do_txn(32'h8003_0000, 1'b1, 4'b0, 100, 1'b0, 1'b0, 1'b0, "mult_to");
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        exp_err = 1'b0; exp_code = 2'b00;
        checks++; if (bus.bus_err !== 1'b0 || bus.err_code !== 2'b00) begin
            errors++; $display("FAIL err_clr got %b/%b exp 0/00", bus.bus_err, bus.err_code);
        end
        // err_clr in the cycle a timeout is raised: the error must stick.
        do_txn(32'h8003_0000, 1'b0, 4'b0101, 100, 1'b0, 1'b1, 1'b0, "to_set_wins");
        // Ready in the final allowed cycle: no error.
        do_txn(32'h8004_0000, 1'b1, 4'b0, TO, 1'b1, 1'b0, 1'b0, "ready_last");
    endtask

    task automatic test_unmapped();
        do_txn(32'h8007_0000, 1'b1, 4'b0, 1, 1'b0, 1'b0, 1'b0, "unmapped");
        do_txn(32'h8002_0000, 1'b1, 4'b0011, 1, 1'b1, 1'b0, 1'b0, "wr_prio");
    endtask

    task automatic test_rst_mid();
        bus.mem_addr  = 32'h8005_0000;
        bus.mem_rstrb = 1'b1;
        bus.periph_ready = 7'b0;
        @(negedge clk);
        bus.mem_rstrb = 1'b0;
        checks++; if (bus.rd_en !== 1'b1 || bus.cs !== 7'b0000010) begin
            errors++; $display("FAIL rst_mid start got rd_en=%b cs=%b exp 1/0000010", bus.rd_en, bus.cs);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_err = 1'b0; exp_code = 2'b00;
        checks++; if ({bus.cs, bus.rd_en, bus.wr_en, bus.wmask_q, bus.mem_rbusy, bus.mem_wbusy, bus.bus_err, bus.err_code} !== 18'b0) begin
            errors++; $display("FAIL rst_mid outputs got %b exp 0", {bus.cs, bus.rd_en, bus.wr_en, bus.wmask_q, bus.mem_rbusy, bus.mem_wbusy, bus.bus_err, bus.err_code});
        end
        do_txn(32'h0000_1000, 1'b1, 4'b0, 1, 1'b0, 1'b0, 1'b0, "rst_mid_ram");
    endtask

    // Random mix of regions, read/write/both and ready timing. Transactions run
    // back-to-back or with short idle gaps.
    task automatic test_back_to_back();
        for (int n = 0; n < 80; n++) begin
            int          r, kind;
            logic [31:0] a;
            logic [3:0]  wm;
            r = $urandom_range(0, 7);
            a = $urandom;
            if (r == 0) a[31] = 1'b0;
            else begin
                a[31] = 1'b1;
                a[19:16] = (r == 7) ? 4'($urandom_range(6, 15)) : 4'(r - 1);
            end
            kind = $urandom_range(0, 2);
            wm   = (kind == 0) ? 4'b0 : 4'($urandom_range(1, 15));
            do_txn(a, kind != 1, wm, $urandom_range(1, TO + 3),
                   ($urandom % 4) == 0, ($urandom % 4) == 0, 1'b1, "random");
            if ($urandom % 2) repeat ($urandom % 3) @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        bus.mem_addr     = 32'b0;
        bus.mem_rstrb    = 1'b0;
        bus.mem_wmask    = 4'b0;
        bus.periph_ready = 7'b0;
        bus.err_clr      = 1'b0;
        exp_err          = 1'b0;
        exp_code         = 2'b00;
        test_reset();
        test_ram_read();
        test_uart_write();
        test_div_read();
        test_timeout();
        test_unmapped();
        test_rst_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
